dds_wavegen: RTL
================

Name: dds_wavegen

Overview:
- Parametrised direct-digital-synthesis waveform generator, successor to the free-running address-counter-plus-sine-ROM block.
- A PHASE_W-bit phase accumulator is stepped by a programmable frequency tuning word (FTW), with an added phase offset.
- Produces sine, square, triangle or sawtooth samples in offset-binary format.
- Sits between the control/register logic and the DAC interface.

Parameters:
- PHASE_W, 24, phase accumulator and FTW width.
- ADDR_W, 8, sine LUT address width: 2^ADDR_W samples per period. Must satisfy ADDR_W >= 3 and ADDR_W <= PHASE_W.
- DATA_W, 8, output sample width. Must satisfy DATA_W >= 2 and DATA_W <= PHASE_W.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- en, input, 1, advance accumulator and mark a sample valid.
- sync, input, 1, zero the phase accumulator.
- ftw_wr, input, 1, load ftw_in into the FTW register.
- ftw_in, input, PHASE_W, new frequency tuning word.
- phase_off, input, PHASE_W, phase offset; sampled every cycle.
- mode, input, 2, waveform select: 0 sine, 1 square, 2 triangle, 3 saw.
- data_out, output, DATA_W, waveform sample, unsigned offset binary.
- data_valid, output, 1, data_out corresponds to an en cycle.

Behaviour:
- Reset: one clock and an asynchronous active-high reset are fixed for this block. While rst is high, clear:
  - acc = 0, ftw = 0
  - all pipeline registers = 0
  - data_out = 0, data_valid = 0
- FTW register: on ftw_wr, ftw <= ftw_in. The new value is first used by the accumulator on the next en cycle.
- Accumulator (S0), with priority order:
  - if sync, acc <= 0, regardless of en;
  - else if en, acc <= acc + ftw, modulo 2^PHASE_W. Wrap-around is silent.
- sync and ftw_wr in the same cycle both take effect.
- Stage S1 (registered):
  - p = acc + phase_off, modulo 2^PHASE_W.
  - Latch pa = p[PHASE_W-1 -: ADDR_W], pd = p[PHASE_W-1 -: DATA_W], mode, and v1 = en & ~sync.
- Stage S2 (registered), output decode and data_valid <= v1:
  - sine: LUT[pa] = 2^(DATA_W-1) + round((2^(DATA_W-1)-1) * sin(2*pi*pa / 2^ADDR_W)).
  - square: pd MSB 0 gives all-ones, else all-zeros.
  - triangle: t = {pd[DATA_W-2:0], 1'b0}; output t if pd MSB is 0, else ~t.
  - saw: pd.
- Latency:
  - The accumulator value present in the cycle en is asserted is not the one sampled; S1 samples acc combinationally each cycle.
  - Acc value A at cycle n appears on data_out at cycle n+2.
  - Output is deterministic: the pipeline runs every cycle, and data_valid qualifies samples.
- mode change: applied per sample, with no glitch beyond the 2-cycle pipeline. An illegal mode cannot occur (2-bit, all encodings used).
- Reset mid-operation: the pipeline flushes immediately. The first valid sample after release uses acc = 0.

Optional Feature:
- Macro: DDS_QUARTER_WAVE_EN.
- Defined:
  - LUT stores magnitudes m[k] = round((2^(DATA_W-1)-1) * sin(2*pi*k / 2^ADDR_W)) for k = 0..2^(ADDR_W-2), i.e. 2^(ADDR_W-2)+1 entries.
  - q = pa mod 2^(ADDR_W-1); idx = q if q <= 2^(ADDR_W-2), else 2^(ADDR_W-1) - q.
  - Output = half + m[idx] when pa MSB is 0, else half - m[idx], where half = 2^(DATA_W-1).
- Undefined: full 2^ADDR_W-entry table.
- Output must be bit-identical and latency unchanged (2 cycles) in both builds. Fold arithmetic occurs before the LUT register.

Decomposition:
- Package dds_pkg:
  - wave_mode_t enum: WAVE_SINE=0, WAVE_SQUARE=1, WAVE_TRI=2, WAVE_SAW=3.
  - Default width constants.
  - Function computing a sine LUT entry, used for table initialisation.
- Sub-module sine_lut (ADDR_W, DATA_W):
  - Registered ROM, 1-cycle read, async active-high rst clears the output.
  - Contains the quarter-wave fold under DDS_QUARTER_WAVE_EN.
  - Replaces the vendor ROM IP so the block is portable.
- Top: accumulator, S1 register, mode mux.

Test Plan (defaults: PHASE_W=24, ADDR_W=8, DATA_W=8):
- Reset: rst high mid-run -> data_out=0, data_valid=0 immediately. After release, ftw=0, so with en=1 data_out stays at 128 (sine).
- Sine step: ftw=0x010000, en=1, mode=0 after sync -> data_out 128, 131, 134, ... Peak 255 at sample 64, 128 at sample 128, minimum 1 at sample 192. data_valid asserts 2 cycles after en.
- Wrap and offset: ftw=0x400000, phase_off=0x400000, mode=3 -> saw sequence 64, 128, 192, 0, 64, ... with no glitch at wrap.
- Triangle/square: ftw=0x010000. mode=2 gives 0, 2, 4, ..., 254 at sample 127, then 255 at sample 128 and descending. mode=1 gives 255 for 128 samples then 0.
- Simultaneous sync+ftw_wr (ftw_in=0x020000) while running -> next sample uses acc=0 (128 sine), then steps of 2 addresses (sine index 0, 2, 4).
- Build with and without DDS_QUARTER_WAVE_EN: sweep all 256 addresses with ftw=0x010000 -> identical sample streams and identical latency.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared types, default widths and sine-table helper for the DDS waveform generator.
// Latency: n/a (package only).
// Backpressure: n/a.
package dds_pkg;

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SAW    = 2'd3
    } wave_mode_t;

    localparam int DDS_PHASE_W = 24;
    localparam int DDS_ADDR_W  = 8;
    localparam int DDS_DATA_W  = 8;

    localparam real DDS_PI = 3.14159265358979323846;

    // Signed sine magnitude round((2^(data_w-1)-1) * sin(2*pi*k/2^addr_w)), ties away from zero.
    function automatic int sine_mag(input int k, input int addr_w, input int data_w);
        real amp;
        real r;
        amp = real'((1 << (data_w - 1)) - 1);
        r   = amp * $sin(2.0 * DDS_PI * real'(k) / real'(1 << addr_w));
        return (r >= 0.0) ? int'($floor(r + 0.5)) : -int'($floor(-r + 0.5));
    endfunction

endpackage

// File: rtl/sine_lut.sv
// Registered sine ROM (offset binary); DDS_QUARTER_WAVE_EN folds a quarter-wave table.
// Latency: 1 cycle from addr_i to data_o; rst clears data_o asynchronously.
// Backpressure: none, reads every cycle.
module sine_lut
    import dds_pkg::*;
#(
    parameter int ADDR_W = DDS_ADDR_W,
    parameter int DATA_W = DDS_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] data_o
);

    localparam logic [DATA_W-1:0] HALF = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;

`ifdef DDS_QUARTER_WAVE_EN
    localparam int QTR = 1 << (ADDR_W - 2);
    localparam logic [ADDR_W-2:0] QTR_A = (ADDR_W-1)'(QTR);

    logic [DATA_W-1:0] mag_rom [QTR+1];
    logic [ADDR_W-2:0] q;
    logic [ADDR_W-2:0] idx;
    logic [DATA_W-1:0] mag;

    for (genvar k = 0; k <= QTR; k++) begin : g_rom
        localparam logic [DATA_W-1:0] ENTRY = DATA_W'(sine_mag(k, ADDR_W, DATA_W));
        assign mag_rom[k] = ENTRY;
    end

    // Mirror the second quarter: half-period minus q equals -q modulo the half-period.
    always_comb begin
        q      = addr_i[ADDR_W-2:0];
        idx    = (q <= QTR_A) ? q : ('0 - q);
        mag    = mag_rom[idx];
        data_d = addr_i[ADDR_W-1] ? (HALF - mag) : (HALF + mag);
    end
`else
    logic [DATA_W-1:0] rom [1 << ADDR_W];

    for (genvar k = 0; k < (1 << ADDR_W); k++) begin : g_rom
        localparam logic [DATA_W-1:0] ENTRY =
            DATA_W'((1 << (DATA_W - 1)) + sine_mag(k, ADDR_W, DATA_W));
        assign rom[k] = ENTRY;
    end

    always_comb begin
        data_d = rom[addr_i];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/dds_wavegen.sv
// DDS waveform generator: phase accumulator + offset, sine/square/triangle/saw decode.
// Latency: accumulator value in cycle n appears on data_out in cycle n+2.
// Backpressure: none; pipeline runs every cycle, data_valid qualifies en samples.
module dds_wavegen
    import dds_pkg::*;
#(
    parameter int PHASE_W = DDS_PHASE_W,
    parameter int ADDR_W  = DDS_ADDR_W,
    parameter int DATA_W  = DDS_DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sync,
    input  logic               ftw_wr,
    input  logic [PHASE_W-1:0] ftw_in,
    input  logic [PHASE_W-1:0] phase_off,
    input  logic [1:0]         mode,
    output logic [DATA_W-1:0]  data_out,
    output logic               data_valid
);

    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [PHASE_W-1:0] ftw_q, ftw_d;
    logic [PHASE_W-1:0] phase_s0;

    logic [ADDR_W-1:0]  pa_q;
    logic [DATA_W-1:0]  pd_q;
    wave_mode_t         mode1_q;
    logic               v1_q;

    logic [DATA_W-1:0]  tri_t;
    logic [DATA_W-1:0]  wave_d, wave_q;
    wave_mode_t         mode2_q;
    logic               vld_q;
    logic [DATA_W-1:0]  sine_dat;

    always_comb begin
        ftw_d = ftw_wr ? ftw_in : ftw_q;
        acc_d = acc_q;
        if (sync) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ftw_q;
        end
        phase_s0 = acc_q + phase_off;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            ftw_q   <= '0;
            pa_q    <= '0;
            pd_q    <= '0;
            mode1_q <= WAVE_SINE;
            v1_q    <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            ftw_q   <= ftw_d;
            pa_q    <= phase_s0[PHASE_W-1 -: ADDR_W];
            pd_q    <= phase_s0[PHASE_W-1 -: DATA_W];
            mode1_q <= wave_mode_t'(mode);
            v1_q    <= en & ~sync;
        end
    end

    // Sine comes from the LUT register; the other shapes share one S2 register.
    always_comb begin
        tri_t  = {pd_q[DATA_W-2:0], 1'b0};
        wave_d = '0;
        case (mode1_q)
            WAVE_SQUARE: wave_d = pd_q[DATA_W-1] ? '0 : '1;
            WAVE_TRI:    wave_d = pd_q[DATA_W-1] ? ~tri_t : tri_t;
            WAVE_SAW:    wave_d = pd_q;
            default:     wave_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wave_q  <= '0;
            mode2_q <= WAVE_SINE;
            vld_q   <= 1'b0;
        end else begin
            wave_q  <= wave_d;
            mode2_q <= mode1_q;
            vld_q   <= v1_q;
        end
    end

    sine_lut #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sine_lut (
        .clk    (clk),
        .rst    (rst),
        .addr_i (pa_q),
        .data_o (sine_dat)
    );

    assign data_out   = (mode2_q == WAVE_SINE) ? sine_dat : wave_q;
    assign data_valid = vld_q;

endmodule
